div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_pkg.sv | 11 +
 rtl/div_step.sv | 22 ++
 rtl/div_seq.sv | 93 +++++++++
 tb/tb_div_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the sequential signed divider.
package div_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step on the {rem,quo} pair.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    // rem[WIDTH] is the bit shifted out; if set, the trial is certainly non-negative
    // and the wrapped (WIDTH+1)-bit difference is still exact.
    assign shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign ge       = rem[WIDTH] | (shifted >= {1'b0, divisor_mag});
    assign diff     = shifted - {1'b0, divisor_mag};
    assign rem_next = ge ? diff : shifted;
    assign quo_next = {quo[WIDTH-2:0], ge};
endmodule

// File: rtl/div_seq.sv
// Sequential signed divider: WIDTH restoring steps, truncating quotient, div-by-zero flag.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             ready,
    output logic             busy
);
    state_t           state, state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   rem, rem_step;
    logic [WIDTH-1:0] quo, quo_step;
    logic [WIDTH-1:0] dmag;
    logic             sign;
    logic             zero;
    logic             last;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign last = (count == CNT_W'(WIDTH));
    assign busy = (state == RUN);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem        (rem),
        .quo        (quo),
        .divisor_mag(dmag),
        .rem_next   (rem_step),
        .quo_next   (quo_step)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // A strobe restarts from any state, including the completion edge.
    always_comb begin
        state_next = state;
        if (ctrl_div) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN:     if (last) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count     <= '0;
            rem       <= '0;
            quo       <= '0;
            dmag      <= '0;
            sign      <= 1'b0;
            zero      <= 1'b0;
            result    <= '0;
            exception <= 1'b0;
            ready     <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (ctrl_div) begin
                quo   <= mag(dividend);
                dmag  <= mag(divisor);
                sign  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                zero  <= (divisor == '0);
                rem   <= '0;
                count <= '0;
            end else if (state == RUN) begin
                if (count != '1) count <= count + 1'b1;
                if (!last) begin
                    rem <= rem_step;
                    quo <= quo_step;
                end else begin
                    result    <= zero ? '0 : (sign ? -quo : quo);
                    exception <= zero;
                    ready     <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// Randomized and directed checks of div_seq against a cycle-level behavioural model.
module tb_div_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         ctrl_div = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] result;
    logic         exception;
    logic         ready;
    logic         busy;

    int checks = 0;
    int passes = 0;

    div_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .ctrl_div (ctrl_div),
        .dividend (dividend),
        .divisor  (divisor),
        .result   (result),
        .exception(exception),
        .ready    (ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Signed quotient, truncating toward zero; wide arithmetic gives MIN/-1 wrap for free.
    function automatic logic [W-1:0] ref_quot(input logic [W-1:0] a, input logic [W-1:0] b);
        longint q;
        if (b == '0) return '0;
        q = longint'($signed(a)) / longint'($signed(b));
        return q[W-1:0];
    endfunction

    // Model: an operation completes W+1 edges after its strobe unless restarted or reset.
    logic         model_on = 1'b0;
    logic         inflight = 1'b0;
    int           n = 0;
    logic [W-1:0] m_dd = '0, m_dv = '0, e_res = '0;
    logic         e_exc = 1'b0, e_rdy = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            model_on = 1'b1;
            inflight = 1'b0;
            e_res    = '0;
            e_exc    = 1'b0;
            e_rdy    = 1'b0;
        end else begin
            e_rdy = 1'b0;
            if (ctrl_div) begin
                inflight = 1'b1;
                n        = 0;
                m_dd     = dividend;
                m_dv     = divisor;
            end else if (inflight) begin
                n++;
                if (n == W + 1) begin
                    inflight = 1'b0;
                    e_rdy    = 1'b1;
                    e_res    = ref_quot(m_dd, m_dv);
                    e_exc    = (m_dv == '0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("busy", busy, inflight);
            chk("ready", ready, e_rdy);
            chk("result", result, e_res);
            chk("exception", exception, e_exc);
        end
    end

    task automatic noise();
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] xr, input logic xe, input string name);
        int lat;
        @(negedge clk);
        ctrl_div = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        ctrl_div = 1'b0; noise();
        lat = 1;
        while (!ready && lat < 60) begin
            @(negedge clk);
            lat++;
            noise();
        end
        chk({name, " latency"}, lat, 34);
        chk({name, " result"}, result, xr);
        chk({name, " exception"}, exception, xe);
        @(negedge clk);
        chk({name, " ready width"}, ready, 0);
        chk({name, " busy after"}, busy, 0);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [W-1:0] a, b;

        repeat (3) @(negedge clk);
        chk("reset result", result, 0);
        chk("reset exception", exception, 0);
        chk("reset ready", ready, 0);
        chk("reset busy", busy, 0);
        reset = 1'b1;

        chk("model pin min/-1", ref_quot(32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        chk("model pin -100/7", ref_quot(-32'sd100, 32'sd7), 32'hFFFF_FFF2);

        run_op(32'd100, 32'd7, 32'd14, 1'b0, "100/7");
        run_op(-32'sd100, 32'sd7, 32'hFFFF_FFF2, 1'b0, "-100/7");
        run_op(32'sd7, -32'sd2, 32'hFFFF_FFFD, 1'b0, "7/-2");
        run_op(32'd5, 32'd0, 32'd0, 1'b1, "5/0");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "min/-1");
        run_op(32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, "min/1");

        // Restart at E10 with 63/9.
        @(negedge clk);
        ctrl_div = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        ctrl_div = 1'b0;
        repeat (9) @(negedge clk);
        ctrl_div = 1'b1; dividend = 32'd63; divisor = 32'd9;
        @(negedge clk);
        ctrl_div = 1'b0; noise();
        lat = 1;
        while (!ready && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("restart latency", lat, 34);
        chk("restart result", result, 7);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        chk("restart extra ready", pulses, 0);

        // Reset sampled at E12.
        @(negedge clk);
        ctrl_div = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        ctrl_div = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort busy", busy, 0);
        chk("abort result", result, 0);
        reset = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        chk("abort no ready", pulses, 0);

        // Random operations, some cut short by a restart, some re-strobed in DONE.
        repeat (60) begin
            case ($urandom_range(0, 4))
                0:       a = 32'h8000_0000;
                1:       a = W'($signed($urandom_range(0, 400)) - 200);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = '1;
                2:       b = W'($signed($urandom_range(0, 40)) - 20);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            @(negedge clk);
            ctrl_div = 1'b1; dividend = a; divisor = b;
            @(negedge clk);
            ctrl_div = 1'b0; noise();
            repeat (($urandom_range(0, 3) == 0) ? $urandom_range(0, 34) : 34) begin
                @(negedge clk);
                noise();
            end
        end
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
